// File: rtl/if_fetch.sv
// if_fetch: MIPS instruction-fetch stage that owns the PC and drives a req/ack instruction-memory port.
// Optional macro IF_DELAY_SLOT_EN: deliver the word fetched at redirect time (branch delay slot).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module if_fetch #(
  parameter logic [`DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   is_stop,
  input  logic                   br_taken,
  input  logic [`DATA_WIDTH-1:0] br_target,
  output logic                   imem_req,
  output logic [`DATA_WIDTH-1:0] imem_addr,
  input  logic                   imem_ack,
  input  logic [`DATA_WIDTH-1:0] imem_rdata,
  output logic [`DATA_WIDTH-1:0] o_code,
  output logic [`DATA_WIDTH-1:0] o_pc,
  output logic                   o_valid
);

  localparam int W = `DATA_WIDTH;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;

  logic [1:0]   state;
  logic [W-1:0] pc;
  logic [W-1:0] buf_code;
  logic [W-1:0] buf_pc;
  logic [W-1:0] tgt;
  logic         redir_pend;

  logic [W-1:0] br_pc;
  logic [W-1:0] pc_inc;
  logic [W-1:0] next_pc;
  logic         squash;
  logic         valid;

  assign br_pc  = br_target & ~W'(3);
  assign pc_inc = pc + W'(4);

  // A same-cycle redirect beats a pending one, which beats sequential fetch.
  assign next_pc = br_taken   ? br_pc :
                   redir_pend ? tgt   : pc_inc;

`ifdef IF_DELAY_SLOT_EN
  assign squash = 1'b0;
`else
  assign squash = br_taken;
`endif

  assign imem_req  = rst && (state != S_HOLD);
  assign imem_addr = pc;

  always_comb begin
    valid  = 1'b0;
    o_code = '0;
    o_pc   = pc;
    case (state)
      S_FETCH: begin
        valid = rst && imem_ack && !squash;
        if (valid) o_code = imem_rdata;
      end
      S_HOLD: begin
        valid = !squash;
        o_pc  = buf_pc;
        if (valid) o_code = buf_code;
      end
      default: ;
    endcase
    o_valid = valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      buf_code   <= '0;
      buf_pc     <= '0;
      tgt        <= '0;
      redir_pend <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            pc         <= next_pc;
            redir_pend <= 1'b0;
            if (is_stop && !squash) begin
              buf_code <= imem_rdata;
              buf_pc   <= pc;
              state    <= S_HOLD;
            end
          end else if (br_taken) begin
            // The outstanding request cannot be cancelled, so remember where to go afterwards.
            tgt <= br_pc;
`ifdef IF_DELAY_SLOT_EN
            redir_pend <= 1'b1;
`else
            state <= S_DROP;
`endif
          end
        end
        S_HOLD: begin
          if (br_taken) pc <= br_pc;
`ifdef IF_DELAY_SLOT_EN
          if (!is_stop) state <= S_FETCH;
`else
          if (!is_stop || br_taken) state <= S_FETCH;
`endif
        end
        S_DROP: begin
          if (imem_ack) begin
            pc    <= br_taken ? br_pc : tgt;
            state <= S_FETCH;
          end else if (br_taken) begin
            tgt <= br_pc;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed vectors for if_fetch with a scoreboard queue checked by an output monitor.
`timescale 1ns/1ps

module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        is_stop = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] o_code;
  logic [31:0] o_pc;
  logic        o_valid;

  int numTests = 0;
  int numFail  = 0;

  int memWait   = 0;
  bit memEnable = 1'b1;
  int waitCnt   = 0;

  logic [63:0] sbQ[$];

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .is_stop   (is_stop),
    .br_taken  (br_taken),
    .br_target (br_target),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .o_code    (o_code),
    .o_pc      (o_pc),
    .o_valid   (o_valid)
  );

  always #5 clk = ~clk;

  // Memory model: acks after memWait wait cycles and returns the address as data.
  always @(posedge clk) begin
    if (!rst || !imem_req || imem_ack) waitCnt <= 0;
    else waitCnt <= waitCnt + 1;
  end

  assign imem_ack   = rst && imem_req && memEnable && (waitCnt >= memWait);
  assign imem_rdata = imem_ack ? imem_addr : 32'hDEAD_BEEF;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numTests++;
    if (actual !== expected) begin
      numFail++;
      $display("[TB] FAIL %s: got %h, required %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic stop, input logic br, input logic [31:0] target);
    is_stop   = stop;
    br_taken  = br;
    br_target = target;
  endtask

  task automatic applyReset();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("rstReq", {31'b0, imem_req}, 32'h0);
    checkOutput("rstValid", {31'b0, o_valid}, 32'h0);
    checkOutput("rstCode", o_code, 32'h0);
    checkOutput("rstPc", o_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic pushSeq(input int first, input int count);
    for (int i = 0; i < count; i++) begin
      logic [31:0] a;
      a = 32'(first + 4 * i);
      sbQ.push_back({a, a});
    end
  endtask

  // Monitor: every word IF/ID actually accepts must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && o_valid && !is_stop) begin
      if (sbQ.size() == 0) begin
        numTests++;
        numFail++;
        $display("[TB] FAIL unexpectedOut: got pc=%h code=%h, required no output", o_pc, o_code);
      end else begin
        logic [63:0] exp;
        exp = sbQ.pop_front();
        checkOutput("monPc", o_pc, exp[63:32]);
        checkOutput("monCode", o_code, exp[31:0]);
      end
    end
  end

  initial begin
    logic dslot;
`ifdef IF_DELAY_SLOT_EN
    dslot = 1'b1;
`else
    dslot = 1'b0;
`endif

    // Zero-wait streaming from the reset vector.
    memWait = 0; memEnable = 1'b1;
    pushSeq(0, 4);
    applyReset();
    repeat (4) @(posedge clk);
    #1;
    memEnable = 1'b0;
    checkOutput("streamReq", {31'b0, imem_req}, 32'h1);
    checkOutput("streamAddr", imem_addr, 32'h10);
    checkOutput("streamEmpty", sbQ.size(), 0);

    // Two wait states: address held three cycles, one valid per word.
    memWait = 2; memEnable = 1'b1;
    pushSeq(0, 2);
    applyReset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("waitAddr", imem_addr, 32'((k / 3) * 4));
      checkOutput("waitValid", {31'b0, o_valid}, {31'b0, (k % 3) == 2});
    end
    @(posedge clk);
    #1;
    memEnable = 1'b0;
    checkOutput("waitEmpty", sbQ.size(), 0);

    // Stall on the ack of 0x10 for three cycles.
    memWait = 0; memEnable = 1'b1;
    pushSeq(0, 6);
    applyReset();
    repeat (4) @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("holdReq", {31'b0, imem_req}, 32'h0);
    checkOutput("holdValid", {31'b0, o_valid}, 32'h1);
    checkOutput("holdPc", o_pc, 32'h10);
    checkOutput("holdCode", o_code, 32'h10);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("releasePc", o_pc, 32'h10);
    @(posedge clk);
    #1;
    checkOutput("resumeAddr", imem_addr, 32'h14);
    checkOutput("resumeReq", {31'b0, imem_req}, 32'h1);
    @(posedge clk);
    #1;
    memEnable = 1'b0;
    checkOutput("holdEmpty", sbQ.size(), 0);

    // Redirect during the ack of 0x20; low target bits must be cleared.
    memWait = 0; memEnable = 1'b1;
    pushSeq(0, 8);
    if (dslot) sbQ.push_back({32'h20, 32'h20});
    pushSeq(32'h100, 2);
    applyReset();
    repeat (8) @(posedge clk);
    #1;
    checkOutput("brAddr", imem_addr, 32'h20);
    applyStimulus(1'b0, 1'b1, 32'h0000_0103);
    @(negedge clk);
    checkOutput("brSlotValid", {31'b0, o_valid}, {31'b0, dslot});
    checkOutput("brSlotCode", o_code, dslot ? 32'h20 : 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("brTarget", imem_addr, 32'h100);
    repeat (2) @(posedge clk);
    #1;
    memEnable = 1'b0;
    checkOutput("brEmpty", sbQ.size(), 0);

    // Redirect while 0x30 is outstanding, acked two cycles later.
    memWait = 0; memEnable = 1'b1;
    pushSeq(0, 12);
    if (dslot) sbQ.push_back({32'h30, 32'h30});
    sbQ.push_back({32'h200, 32'h200});
    applyReset();
    repeat (12) @(posedge clk);
    #1;
    memWait = 2;
    applyStimulus(1'b0, 1'b1, 32'h200);
    @(negedge clk);
    checkOutput("dropValid0", {31'b0, o_valid}, 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("dropValid1", {31'b0, o_valid}, 32'h0);
    checkOutput("dropAddr1", imem_addr, 32'h30);
    checkOutput("dropReq1", {31'b0, imem_req}, 32'h1);
    @(negedge clk);
    checkOutput("dropAckValid", {31'b0, o_valid}, {31'b0, dslot});
    checkOutput("dropAckCode", o_code, dslot ? 32'h30 : 32'h0);
    checkOutput("dropAddr2", imem_addr, 32'h30);
    @(posedge clk);
    #1;
    memWait = 0;
    checkOutput("dropTarget", imem_addr, 32'h200);
    @(posedge clk);
    #1;
    memWait = 5;

    // Asynchronous reset in the middle of a wait.
    @(posedge clk);
    #3;
    checkOutput("midWaitReq", {31'b0, imem_req}, 32'h1);
    rst = 1'b0;
    #1;
    checkOutput("asyncReq", {31'b0, imem_req}, 32'h0);
    checkOutput("asyncAddr", imem_addr, 32'h0);
    checkOutput("asyncPc", o_pc, 32'h0);
    checkOutput("asyncValid", {31'b0, o_valid}, 32'h0);
    checkOutput("dropEmpty", sbQ.size(), 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", numTests, numFail);
    $finish;
  end

endmodule
